game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter CLK_HZ, 50000000, clk cycles per one-second timer tick.
REQ-002 Parameter TURN_TIME, 15, turn length in seconds; legal range 1..31.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse, debounced upstream.
REQ-007 btn_move  input  1  single-cycle pulse; advance cursor.
REQ-008 btn_place  input  1  single-cycle pulse; mark cell under cursor.
REQ-009 cell_addr  input  4  board read address from renderer, 0..8.
REQ-010 cell_owner  output  2  combinational owner of cell_addr: 0 empty, 1 P1, 2 P2; 0 for cell_addr>8.
REQ-011 sel_position  output  4  cursor cell, 0..8.
REQ-012 player  output  2  player to move, 1 or 2.
REQ-013 winner  output  2  0 none, 1 P1, 2 P2, 3 draw.
REQ-014 winner_s  output  1  high in OVER state.
REQ-015 menu  output  1  high in MENU state.
REQ-016 pos1, pos2, pos3  output  4 each  winning-line cells, ascending; 15 when no winning line.
REQ-017 _time  output  5  seconds remaining in current turn.

Function
REQ-018 FSM states MENU, PLAY, CHECK, OVER; all outputs except cell_owner registered.
REQ-019 MENU: menu=1; start -> clear board, player=1, sel_position=0, _time=TURN_TIME, prescaler=0, winner=0, pos*=15, next PLAY.
REQ-020 PLAY: prescaler counts 0..CLK_HZ-1, wraps; tick asserted in the cycle it equals CLK_HZ-1.
REQ-021 PLAY, btn_move: sel_position = 8 ? 0 : sel_position+1.
REQ-022 PLAY, btn_place on empty cell: cell=player, next CHECK; on occupied cell: ignored, no state change.
REQ-023 PLAY, tick with _time>0: _time decrements by 1.
REQ-024 PLAY, tick with _time==0 (timeout): player toggles, _time=TURN_TIME, board unchanged.
REQ-025 Simultaneous events in PLAY: valid place overrides move and tick (sel_position and _time unchanged that cycle); move and tick together both take effect.
REQ-026 start ignored in PLAY and CHECK.
REQ-027 CHECK lasts exactly one cycle; it tests lines in order 0-1-2, 3-4-5, 6-7-8, 0-3-6, 1-4-7, 2-5-8, 0-4-8, 2-4-6; first line fully owned by player wins.
REQ-028 CHECK win: winner=player, pos1..pos3=line cells, next OVER.
REQ-029 CHECK no win, all 9 cells occupied: winner=3, pos*=15, next OVER.
REQ-030 CHECK otherwise: player toggles, _time=TURN_TIME, prescaler=0, sel_position kept, next PLAY.
REQ-031 Latency: place pulse at cycle N -> winner/winner_s or new player visible at cycle N+2.
REQ-032 OVER: winner_s=1; board, winner, pos*, player and _time frozen; start -> MENU (board retained until next game start).
REQ-033 btn_move, btn_place ignored in MENU, CHECK, OVER.

Reset
REQ-034 rst in any state, including mid-CHECK: state=MENU, board all 0, menu=1, winner_s=0, winner=0, player=1, sel_position=0, _time=TURN_TIME, pos1..pos3=15, prescaler=0.

Verification (bench uses CLK_HZ=4, TURN_TIME=3)
REQ-035 Reset, start, then places at cells 0,3,1,4,2 (move pulses between) -> after final place + 2 cycles winner=1, winner_s=1, pos1/2/3=0/1/2, cell_owner(3)=2.
REQ-036 Start, no input for 4 ticks -> _time 3,2,1,0 then player=2, _time=3 on fourth tick.
REQ-037 Cursor at 8 plus btn_move -> sel_position=0; btn_place on occupied cell -> player and state unchanged.
REQ-038 Full board with no line (sequence 0,1,2,4,3,5,7,6,8) -> winner=3, pos*=15, winner_s=1.
REQ-039 btn_place and tick in the same cycle -> cell written, _time not decremented; rst during CHECK -> MENU, board cleared next cycle.

Source files
------------

// File: rtl/game_controller.sv
`timescale 1ns/1ps
// Tic-tac-toe game sequencer: cursor/placement handling, per-turn countdown timer,
// win/draw detection and a renderer-facing combinational board read port.
module game_controller #(
  parameter int CLK_HZ    = 50000000,
  parameter int TURN_TIME = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_move,
  input  logic       btn_place,
  input  logic [3:0] cell_addr,
  output logic [1:0] cell_owner,
  output logic [3:0] sel_position,
  output logic [1:0] player,
  output logic [1:0] winner,
  output logic       winner_s,
  output logic       menu,
  output logic [3:0] pos1,
  output logic [3:0] pos2,
  output logic [3:0] pos3,
  output logic [4:0] _time
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_HZ - 1);
  localparam logic [4:0] T_INIT = 5'(TURN_TIME);
  localparam logic [3:0] NO_POS = 4'hF;

  typedef enum logic [1:0] {S_MENU, S_PLAY, S_CHECK, S_OVER} state_t;

  state_t        state_q, state_d;
  logic [1:0]    board_q [9];
  logic [1:0]    board_d [9];
  logic [1:0]    player_q, player_d;
  logic [3:0]    sel_q, sel_d;
  logic [4:0]    time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    winner_q, winner_d;
  logic [3:0]    pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
  logic          menu_q, menu_d, winner_s_q, winner_s_d;

  logic [1:0]  cur_owner;
  logic        full;
  logic [8:0]  own;
  logic        win_found;
  logic [11:0] win_cells;
  logic        tick;
  logic [1:0]  other_player;

  function automatic logic [11:0] line_cells(input int unsigned l);
    case (l)
      0:       line_cells = {4'd0, 4'd1, 4'd2};
      1:       line_cells = {4'd3, 4'd4, 4'd5};
      2:       line_cells = {4'd6, 4'd7, 4'd8};
      3:       line_cells = {4'd0, 4'd3, 4'd6};
      4:       line_cells = {4'd1, 4'd4, 4'd7};
      5:       line_cells = {4'd2, 4'd5, 4'd8};
      6:       line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  always_comb begin
    cell_owner = '0;
    cur_owner  = '0;
    full       = 1'b1;
    own        = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (cell_addr == 4'(i)) cell_owner = board_q[i];
      if (sel_q == 4'(i))     cur_owner  = board_q[i];
      if (board_q[i] == 2'd0) full       = 1'b0;
      own[i] = (board_q[i] == player_q);
    end
  end

  // Scan lines in fixed order; the first line fully owned by the mover wins.
  always_comb begin
    logic [11:0] cells;
    logic [8:0]  mask;
    cells     = '0;
    mask      = '0;
    win_found = 1'b0;
    win_cells = {NO_POS, NO_POS, NO_POS};
    for (int unsigned l = 0; l < 8; l++) begin
      cells = line_cells(l);
      mask  = (9'd1 << cells[11:8]) | (9'd1 << cells[7:4]) | (9'd1 << cells[3:0]);
      if (!win_found && ((own & mask) == mask)) begin
        win_found = 1'b1;
        win_cells = cells;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    for (int unsigned i = 0; i < 9; i++) board_d[i] = board_q[i];
    player_d = player_q;
    sel_d    = sel_q;
    time_d   = time_q;
    presc_d  = presc_q;
    winner_d = winner_q;
    pos1_d   = pos1_q;
    pos2_d   = pos2_q;
    pos3_d   = pos3_q;
    tick     = (presc_q == PS_MAX);
    other_player = (player_q == 2'd1) ? 2'd2 : 2'd1;

    case (state_q)
      S_MENU: begin
        if (start) begin
          for (int unsigned i = 0; i < 9; i++) board_d[i] = '0;
          player_d = 2'd1;
          sel_d    = '0;
          time_d   = T_INIT;
          presc_d  = '0;
          winner_d = '0;
          pos1_d   = NO_POS;
          pos2_d   = NO_POS;
          pos3_d   = NO_POS;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        // A valid place swallows any move/tick arriving in the same cycle.
        if (btn_place && (cur_owner == 2'd0)) begin
          for (int unsigned i = 0; i < 9; i++)
            if (sel_q == 4'(i)) board_d[i] = player_q;
          state_d = S_CHECK;
        end else begin
          if (btn_move) sel_d = (sel_q == 4'd8) ? '0 : sel_q + 4'd1;
          if (tick) begin
            if (time_q != '0) begin
              time_d = time_q - 5'd1;
            end else begin
              player_d = other_player;
              time_d   = T_INIT;
            end
          end
        end
      end
      S_CHECK: begin
        if (win_found) begin
          winner_d = player_q;
          pos1_d   = win_cells[11:8];
          pos2_d   = win_cells[7:4];
          pos3_d   = win_cells[3:0];
          state_d  = S_OVER;
        end else if (full) begin
          winner_d = 2'd3;
          pos1_d   = NO_POS;
          pos2_d   = NO_POS;
          pos3_d   = NO_POS;
          state_d  = S_OVER;
        end else begin
          player_d = other_player;
          time_d   = T_INIT;
          presc_d  = '0;
          state_d  = S_PLAY;
        end
      end
      S_OVER: begin
        if (start) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase

    menu_d     = (state_d == S_MENU);
    winner_s_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_MENU;
      for (int unsigned i = 0; i < 9; i++) board_q[i] <= '0;
      player_q   <= 2'd1;
      sel_q      <= '0;
      time_q     <= T_INIT;
      presc_q    <= '0;
      winner_q   <= '0;
      pos1_q     <= NO_POS;
      pos2_q     <= NO_POS;
      pos3_q     <= NO_POS;
      menu_q     <= 1'b1;
      winner_s_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int unsigned i = 0; i < 9; i++) board_q[i] <= board_d[i];
      player_q   <= player_d;
      sel_q      <= sel_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      winner_q   <= winner_d;
      pos1_q     <= pos1_d;
      pos2_q     <= pos2_d;
      pos3_q     <= pos3_d;
      menu_q     <= menu_d;
      winner_s_q <= winner_s_d;
    end
  end

  assign sel_position = sel_q;
  assign player       = player_q;
  assign winner       = winner_q;
  assign winner_s     = winner_s_q;
  assign menu         = menu_q;
  assign pos1         = pos1_q;
  assign pos2         = pos2_q;
  assign pos3         = pos3_q;
  assign _time        = time_q;

endmodule
